// File: rtl/comparator_max_tracker_if.sv
// Bundle of the tracker's handshake, comparator and result signals.
// The master side is the upstream producer/environment. The slave side is the tracker.
interface comparator_max_tracker_if #(
   parameter int MSB   = 128,
   parameter int IDX_W = 8
);
   logic             start;
   logic [IDX_W-1:0] frame_len;
   logic             in_valid;
   logic [MSB-1:0]   in_data;
   logic             in_ready;
   logic [MSB-1:0]   cmp_a;
   logic [MSB-1:0]   cmp_b;
   logic             cmp_greater;
   logic             cmp_less;
   logic             cmp_equal;
   logic [MSB-1:0]   max_value;
   logic [IDX_W-1:0] max_index;
   logic [IDX_W-1:0] tie_count;
   logic             busy;
   logic             done;
   logic             err;

   modport master (
      output start, frame_len, in_valid, in_data,
      output cmp_greater, cmp_less, cmp_equal,
      input  in_ready, cmp_a, cmp_b,
      input  max_value, max_index, tie_count, busy, done, err
   );

   modport slave (
      input  start, frame_len, in_valid, in_data,
      input  cmp_greater, cmp_less, cmp_equal,
      output in_ready, cmp_a, cmp_b,
      output max_value, max_index, tie_count, busy, done, err
   );
endinterface

// File: rtl/comparator_max_tracker.sv
// Running-maximum tracker that sits downstream of an external magnitude comparator.
// Each accepted sample is compared against the current maximum via cmp_a/cmp_b.
// The comparator's flags decide whether the max, its first index or the tie count changes.
module comparator_max_tracker #(
   parameter int MSB   = 128,
   parameter int IDX_W = 8
) (
   input logic clk,
   input logic rst,
   comparator_max_tracker_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FIRST = 2'd1,
      RUN   = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [MSB-1:0]   max_value_q, max_value_d;
   logic [IDX_W-1:0] max_index_q, max_index_d;
   logic [IDX_W-1:0] tie_count_q, tie_count_d;
   logic [IDX_W-1:0] sample_cnt_q, sample_cnt_d;
   logic [IDX_W-1:0] frame_len_q, frame_len_d;
   logic             err_q, err_d;

   logic             accepting;
   logic             xfer;
   logic [2:0]       flags;
   logic [IDX_W-1:0] last_idx;

   // Decode the handshake and the comparator flags.
   // Only exactly one raised flag is trusted. Every other pattern falls through to the error path.
   always_comb begin
      accepting = (state_q == FIRST) || (state_q == RUN);
      xfer      = accepting && bus.in_valid;
      flags     = {bus.cmp_greater, bus.cmp_less, bus.cmp_equal};
      last_idx  = frame_len_q - IDX_W'(1);
   end

   // State and result registers.
   // The reset is asynchronous, so a partial frame is dropped the moment rst rises.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         max_value_q  <= '0;
         max_index_q  <= '0;
         tie_count_q  <= '0;
         sample_cnt_q <= '0;
         frame_len_q  <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         max_value_q  <= max_value_d;
         max_index_q  <= max_index_d;
         tie_count_q  <= tie_count_d;
         sample_cnt_q <= sample_cnt_d;
         frame_len_q  <= frame_len_d;
         err_q        <= err_d;
      end
   end

   // Next-state and next-result logic.
   // Everything holds by default, so a stalled handshake leaves the tracker untouched.
   always_comb begin
      state_d      = state_q;
      max_value_d  = max_value_q;
      max_index_d  = max_index_q;
      tie_count_d  = tie_count_q;
      sample_cnt_d = sample_cnt_q;
      frame_len_d  = frame_len_q;
      err_d        = err_q;

      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               frame_len_d  = bus.frame_len;
               err_d        = 1'b0;
               max_value_d  = '0;
               max_index_d  = '0;
               tie_count_d  = '0;
               sample_cnt_d = '0;
               if (bus.frame_len == '0) begin
                  state_d = DONE;
               end else begin
                  state_d = FIRST;
               end
            end
         end

         FIRST: begin
            if (xfer) begin
               max_value_d  = bus.in_data;
               max_index_d  = '0;
               tie_count_d  = '0;
               sample_cnt_d = IDX_W'(1);
               if (frame_len_q == IDX_W'(1)) begin
                  state_d = DONE;
               end else begin
                  state_d = RUN;
               end
            end
         end

         RUN: begin
            if (xfer) begin
               case (flags)
                  3'b100: begin
                     max_value_d = bus.in_data;
                     max_index_d = sample_cnt_q;
                     tie_count_d = '0;
                  end
                  3'b001: begin
                     tie_count_d = tie_count_q + IDX_W'(1);
                  end
                  3'b010: begin
                  end
                  default: begin
                     err_d = 1'b1;
                  end
               endcase
               sample_cnt_d = sample_cnt_q + IDX_W'(1);
               if (sample_cnt_q == last_idx) begin
                  state_d = DONE;
               end
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Drive the comparator operands and the status/result outputs straight from state.
   always_comb begin
      bus.in_ready  = accepting;
      bus.busy      = accepting;
      bus.done      = (state_q == DONE);
      bus.err       = err_q;
      bus.cmp_a     = bus.in_data;
      bus.cmp_b     = max_value_q;
      bus.max_value = max_value_q;
      bus.max_index = max_index_q;
      bus.tie_count = tie_count_q;
   end

endmodule

// File: doc/comparator_max_tracker.md
Name: comparator_max_tracker

Overview:
- Sequential stage directly downstream of the MSB-bit magnitude comparator (outputs greater/less/equal).
- Accepts a frame of samples over a valid/ready handshake and tracks the running maximum of the frame.
- Drives the comparator operands (a = incoming sample, b = current max) and consumes its flags to update max value, index and tie count.
- Reports the results with a one-cycle done pulse.

Parameters:
- MSB, 128, sample/operand width; must match the comparator's MSB.
- IDX_W, 8, width of frame length, sample index and tie counter; max frame is 2^IDX_W-1 samples.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a frame; sampled only in IDLE.
- frame_len  input  IDX_W  number of samples in the frame; latched on accepted start.
- in_valid  input  1  sample valid.
- in_data  input  MSB  sample value.
- in_ready  output  1  tracker accepts a sample this cycle.
- cmp_a  output  MSB  comparator operand a; always equals in_data.
- cmp_b  output  MSB  comparator operand b; always equals max_value.
- cmp_greater  input  1  comparator flag, a>b.
- cmp_less  input  1  comparator flag, a<b.
- cmp_equal  input  1  comparator flag, a==b.
- max_value  output  MSB  running/final maximum.
- max_index  output  IDX_W  index (0-based) of the first occurrence of the maximum.
- tie_count  output  IDX_W  number of later samples equal to the current maximum.
- busy  output  1  high in FIRST and RUN.
- done  output  1  one-cycle pulse; results valid.
- err  output  1  sticky: non-one-hot comparator flags seen.

Behaviour:
- Reset (async, any state, mid-frame included):
  - state=IDLE.
  - max_value, max_index, tie_count, sample_cnt and frame_len_q cleared to 0.
  - done, err, busy and in_ready all 0.
  - Any partial frame is discarded.
- Handshake: a sample transfers on the rising edge where in_valid && in_ready. in_ready=1 only in FIRST and RUN. in_data is don't-care when in_valid=0.
- IDLE:
  - start=1 latches frame_len into frame_len_q, clears err, max_value, max_index and tie_count.
  - frame_len==0 -> DONE (results all 0).
  - Otherwise -> FIRST.
  - start=0: results hold from the previous frame.
- FIRST:
  - On transfer: max_value<=in_data, max_index<=0, tie_count<=0, sample_cnt<=1. Flags ignored.
  - frame_len_q==1 -> DONE, else -> RUN.
- RUN, on transfer:
  - cmp_greater only: max_value<=in_data, max_index<=sample_cnt, tie_count<=0.
  - cmp_equal only: tie_count<=tie_count+1. Value and index hold, so the first occurrence wins.
  - cmp_less only: no change.
  - Any other flag combination (none, or more than one): err<=1, treated as less.
  - Every transfer: sample_cnt<=sample_cnt+1. When sample_cnt==frame_len_q-1 -> DONE.
  - No transfer: all state holds; in_valid stalls of any length are allowed.
- DONE: done=1 for exactly one cycle, in_ready=0, -> IDLE. Outputs hold until the next accepted start.
- Latency: done is asserted in the cycle after the clock edge of the final transfer. A frame of N samples with no stalls takes N+2 cycles from start to done.
- start is ignored while busy or in DONE.
- Comparator is combinational; flags must settle within the same cycle the tracker drives cmp_a/cmp_b. No flag registering.
- Counters need no saturation: tie_count ≤ frame_len-1 < 2^IDX_W.
- Widths: all value storage is MSB bits. No arithmetic on data; comparison is delegated entirely to the comparator.

Test Plan:
- Bench instantiates comparator_d (MSB=128) wired to cmp_*. Notation: X = {4'hX, 124'b0}.
- Frame_len=4, samples A, D, E, C, no stalls -> done 6 cycles after start; max_value=E, max_index=2, tie_count=0, err=0.
- Frame_len=5, samples D, F, F, A, F -> max_value=F, max_index=1, tie_count=2.
- Frame_len=3, samples 0, 0, 0, with in_valid deasserted 3 cycles between each -> max_value=0, max_index=0, tie_count=2; done only after the third transfer.
- Frame_len=0 -> done 2 cycles after start, in_ready never asserted, all results 0. Frame_len=1 with sample E -> max_value=E, max_index=0.
- rst pulsed after the 2nd of 4 samples -> all outputs 0 immediately (async). Next start with frame_len=2, samples C, D -> max_value=D, max_index=1.
- Comparator replaced by a stub forcing greater=less=1 on the 2nd sample -> err=1 at done; max unchanged by that sample. err clears on the next start.
